snoop_bus_scheduler: RTL and testbench
======================================

SNOOP_BUS_SCHEDULER -- requirements
Module: snoop_bus_scheduler

Interface
REQ-001 SHALL have parameters: MSG_BITS, 4, bus message width; NUM_CACHES, 4, L1 ports on shared bus; TIMEOUT_CYCLES, 255, watchdog limit.
REQ-002 SHALL have ports, clock and reset first:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- cache2mem_msg  in  NUM_CACHES*MSG_BITS  per-L1 bus message; port i is bits [i*MSG_BITS +: MSG_BITS].
- mem2controller_msg  in  MSG_BITS  L2 message.
- bus_control  out  log2(NUM_CACHES+1)  bus mux select; value NUM_CACHES selects L2.
- bus_en  out  1  bus mux output valid.
- curr_master  out  NUM_CACHES  one-hot granted L1.
- req_ready  out  1  L2 response phase active.
- timeout  out  1  watchdog abort pulse.

Function
REQ-003 SHALL treat port i as requesting when its message is R_REQ, WB_REQ, FLUSH, FLUSH_S, WS_BCAST or RFO_BCAST.
REQ-004 SHALL implement states IDLE, GRANT, INTERVENE and RESP; every output SHALL be a register.
REQ-005 IDLE: outputs bus_en=0, curr_master=0, req_ready=0 and bus_control=0; when any port requests, the next state SHALL be GRANT with the round-robin winner.
REQ-006 Round-robin search SHALL start at last_grant+1 modulo NUM_CACHES and wrap from NUM_CACHES-1 to 0; last_grant resets to NUM_CACHES-1, so port 0 wins first.
REQ-007 Grant latency SHALL be exactly one cycle from the request seen in IDLE to bus_en=1.
REQ-008 GRANT: outputs bus_control=winner, bus_en=1, curr_master=one-hot(winner), req_ready=0.
REQ-009 GRANT to INTERVENE SHALL occur when a non-master port drives C_WB or C_FLUSH; the lowest such index is chosen and bus_control switches to it; curr_master is unchanged.
REQ-010 INTERVENE to GRANT SHALL occur when the intervening port's message leaves C_WB/C_FLUSH.
REQ-011 GRANT to RESP SHALL occur on an L2 message of MEM_RESP, MEM_RESP_S or MEM_C_RESP; if intervention and response occur in the same cycle, intervention wins.
REQ-012 RESP: outputs bus_control=NUM_CACHES, bus_en=1, req_ready=1, curr_master held.
REQ-013 RESP to GRANT SHALL occur when the master drives HOLD_BUS; no re-arbitration occurs and last_grant is unchanged.
REQ-014 RESP to IDLE SHALL occur when the master drives NO_REQ; last_grant is then set to the master.
REQ-015 GRANT to IDLE SHALL occur when the master withdraws (NO_REQ) before a response; last_grant is set to the master.
REQ-016 An L2 response seen in IDLE SHALL be ignored.
REQ-017 Requests from non-master ports SHALL be ignored outside IDLE; a port is never granted twice in a row while another port requests.

Reset
REQ-018 On reset=1 at a clock edge, the block SHALL enter IDLE and clear all outputs, last_grant=NUM_CACHES-1 and the watchdog counter, from any state including mid-GRANT or mid-RESP.
REQ-019 The first arbitration SHALL occur in the cycle after reset deasserts.

Configuration
REQ-020 With macro BUS_WATCHDOG_EN defined, a counter SHALL increment each cycle in GRANT or INTERVENE and clear on entering RESP or IDLE.
REQ-021 With BUS_WATCHDOG_EN defined, reaching TIMEOUT_CYCLES SHALL force IDLE, pulse timeout=1 for one cycle and set last_grant to the master.
REQ-022 Without BUS_WATCHDOG_EN, no counter SHALL exist, timeout SHALL be constant 0, and GRANT SHALL wait indefinitely.

Verification
REQ-023 After reset, ports 0 and 2 drive R_REQ in the same cycle -> next cycle bus_control=0, curr_master=4'b0001, bus_en=1.
REQ-024 Port 3 served and releases, then ports 0 and 3 request -> port 0 granted (wrap-around); port 3 is not regranted.
REQ-025 Master 1 in GRANT, port 2 drives C_WB for 2 cycles -> bus_control=2 for 2 cycles, curr_master=4'b0010 throughout, then bus_control=1.
REQ-026 L2 drives MEM_RESP, then the master drives HOLD_BUS -> one RESP cycle with bus_control=4 and req_ready=1, then GRANT on the same master.
REQ-027 With BUS_WATCHDOG_EN and TIMEOUT_CYCLES=8, grant with no L2 response -> timeout=1 on the 8th grant cycle, then IDLE.
REQ-028 Reset asserted in RESP -> next cycle bus_en=0, req_ready=0, curr_master=0.

Source files
------------

// File: rtl/snoop_bus_scheduler.sv
// Round-robin shared snoop-bus scheduler with cache-to-cache intervention and L2 response phases.
// Optional bus watchdog: define BUS_WATCHDOG_EN to enable the grant-phase timeout.
module snoop_bus_scheduler #(
   parameter int MSG_BITS       = 4,
   parameter int NUM_CACHES     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_CACHES*MSG_BITS-1:0]  cache2mem_msg,
   input  logic [MSG_BITS-1:0]             mem2controller_msg,
   output logic [$clog2(NUM_CACHES+1)-1:0] bus_control,
   output logic                            bus_en,
   output logic [NUM_CACHES-1:0]           curr_master,
   output logic                            req_ready,
   output logic                            timeout
);
   localparam int BC_W  = $clog2(NUM_CACHES+1);
   localparam int IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
   localparam logic [NUM_CACHES-1:0] ONE = NUM_CACHES'(1);

   // Bus message encoding shared with the L1/L2 controllers.
   localparam logic [MSG_BITS-1:0] NO_REQ     = MSG_BITS'(0);
   localparam logic [MSG_BITS-1:0] R_REQ      = MSG_BITS'(1);
   localparam logic [MSG_BITS-1:0] WB_REQ     = MSG_BITS'(2);
   localparam logic [MSG_BITS-1:0] FLUSH      = MSG_BITS'(3);
   localparam logic [MSG_BITS-1:0] FLUSH_S    = MSG_BITS'(4);
   localparam logic [MSG_BITS-1:0] WS_BCAST   = MSG_BITS'(5);
   localparam logic [MSG_BITS-1:0] RFO_BCAST  = MSG_BITS'(6);
   localparam logic [MSG_BITS-1:0] C_WB       = MSG_BITS'(7);
   localparam logic [MSG_BITS-1:0] C_FLUSH    = MSG_BITS'(8);
   localparam logic [MSG_BITS-1:0] MEM_RESP   = MSG_BITS'(9);
   localparam logic [MSG_BITS-1:0] MEM_RESP_S = MSG_BITS'(10);
   localparam logic [MSG_BITS-1:0] MEM_C_RESP = MSG_BITS'(11);
   localparam logic [MSG_BITS-1:0] HOLD_BUS   = MSG_BITS'(12);

   typedef enum logic [1:0] {IDLE, GRANT, INTERVENE, RESP} state_t;

   function automatic logic is_req(input logic [MSG_BITS-1:0] m);
      return (m == R_REQ) || (m == WB_REQ) || (m == FLUSH) || (m == FLUSH_S) ||
             (m == WS_BCAST) || (m == RFO_BCAST);
   endfunction

   state_t                              state;
   logic [NUM_CACHES-1:0][MSG_BITS-1:0] msg;
   logic [NUM_CACHES-1:0]               req, cxfer;
   logic [IDX_W-1:0]                    master, iv_idx, last_grant, rr_win, iv_win;
   logic                                any_req, iv_hit, l2_resp, m_idle, m_hold;
   logic                                wd_fire;

   assign msg     = cache2mem_msg;
   assign l2_resp = (mem2controller_msg == MEM_RESP) || (mem2controller_msg == MEM_RESP_S) ||
                    (mem2controller_msg == MEM_C_RESP);
   assign m_idle  = (msg[master] == NO_REQ);
   assign m_hold  = (msg[master] == HOLD_BUS);

   always_comb begin
      req   = '0;
      cxfer = '0;
      for (int i = 0; i < NUM_CACHES; i++) begin
         req[i]   = is_req(msg[i]);
         cxfer[i] = (msg[i] == C_WB) || (msg[i] == C_FLUSH);
      end
   end

   // Walk from farthest to nearest so the port right after last_grant wins.
   always_comb begin
      any_req = 1'b0;
      rr_win  = '0;
      for (int k = NUM_CACHES; k >= 1; k--) begin
         if (req[(int'(last_grant) + k) % NUM_CACHES]) begin
            any_req = 1'b1;
            rr_win  = IDX_W'((int'(last_grant) + k) % NUM_CACHES);
         end
      end
   end

   always_comb begin
      iv_hit = 1'b0;
      iv_win = '0;
      for (int i = NUM_CACHES-1; i >= 0; i--) begin
         if (cxfer[i] && (IDX_W'(i) != master)) begin
            iv_hit = 1'b1;
            iv_win = IDX_W'(i);
         end
      end
   end

`ifdef BUS_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES+1);
   logic [CW-1:0] wd_cnt;
   logic          in_wd, leave_wd;

   assign in_wd    = (state == GRANT) || (state == INTERVENE);
   assign leave_wd = (state == GRANT) && !iv_hit && (m_idle || l2_resp);
   assign wd_fire  = in_wd && (wd_cnt == CW'(TIMEOUT_CYCLES-1));

   // timeout is raised one edge early so it is visible during the final grant cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         wd_cnt  <= (in_wd && !leave_wd && !wd_fire) ? wd_cnt + 1'b1 : '0;
         timeout <= in_wd && !leave_wd && !wd_fire && (wd_cnt == CW'(TIMEOUT_CYCLES-2));
      end
   end
`else
   assign wd_fire = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         master      <= '0;
         iv_idx      <= '0;
         last_grant  <= IDX_W'(NUM_CACHES-1);
         bus_control <= '0;
         bus_en      <= 1'b0;
         curr_master <= '0;
         req_ready   <= 1'b0;
      end else if (wd_fire) begin
         state       <= IDLE;
         last_grant  <= master;
         bus_control <= '0;
         bus_en      <= 1'b0;
         curr_master <= '0;
         req_ready   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               state       <= GRANT;
               master      <= rr_win;
               bus_control <= BC_W'(rr_win);
               bus_en      <= 1'b1;
               curr_master <= ONE << rr_win;
            end
            // Intervention beats everything; a withdrawal beats a same-cycle L2 response.
            GRANT: if (iv_hit) begin
               state       <= INTERVENE;
               iv_idx      <= iv_win;
               bus_control <= BC_W'(iv_win);
            end else if (m_idle) begin
               state       <= IDLE;
               last_grant  <= master;
               bus_control <= '0;
               bus_en      <= 1'b0;
               curr_master <= '0;
            end else if (l2_resp) begin
               state       <= RESP;
               bus_control <= BC_W'(NUM_CACHES);
               req_ready   <= 1'b1;
            end
            INTERVENE: if (!cxfer[iv_idx]) begin
               state       <= GRANT;
               bus_control <= BC_W'(master);
            end
            RESP: if (m_hold) begin
               state       <= GRANT;
               bus_control <= BC_W'(master);
               req_ready   <= 1'b0;
            end else if (m_idle) begin
               state       <= IDLE;
               last_grant  <= master;
               bus_control <= '0;
               bus_en      <= 1'b0;
               curr_master <= '0;
               req_ready   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_snoop_bus_scheduler.sv
module tb_snoop_bus_scheduler;
  localparam logic [3:0] NO_REQ = 4'd0, R_REQ = 4'd1, WB_REQ = 4'd2, FLUSH = 4'd3,
                         FLUSH_S = 4'd4, WS_BCAST = 4'd5, RFO_BCAST = 4'd6, C_WB = 4'd7,
                         C_FLUSH = 4'd8, MEM_RESP = 4'd9, MEM_RESP_S = 4'd10,
                         MEM_C_RESP = 4'd11, HOLD_BUS = 4'd12;

  typedef struct packed {
    logic [2:0] bc;
    logic       en;
    logic [3:0] cm;
    logic       rr;
    logic       to;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cache2mem_msg = '0;
  logic [3:0]  mem2controller_msg = '0;
  logic [2:0]  bus_control;
  logic        bus_en;
  logic [3:0]  curr_master;
  logic        req_ready;
  logic        timeout;

  int   checks = 0;
  int   errors = 0;
  int   vid = 0;
  exp_t q[$];
  int   tq[$];

  snoop_bus_scheduler #(.MSG_BITS(4), .NUM_CACHES(4), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .cache2mem_msg(cache2mem_msg),
    .mem2controller_msg(mem2controller_msg), .bus_control(bus_control), .bus_en(bus_en),
    .curr_master(curr_master), .req_ready(req_ready), .timeout(timeout)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(int bc, bit en, int cm, bit rr, bit to);
    exp_t e;
    e.bc = 3'(bc); e.en = en; e.cm = 4'(cm); e.rr = rr; e.to = to;
    return e;
  endfunction
  function automatic exp_t e_idle();            return mk(0, 0, 0, 0, 0);       endfunction
  function automatic exp_t e_g(int i);          return mk(i, 1, 1 << i, 0, 0);  endfunction
  function automatic exp_t e_iv(int iv, int m); return mk(iv, 1, 1 << m, 0, 0); endfunction
  function automatic exp_t e_rsp(int m);        return mk(4, 1, 1 << m, 1, 0);  endfunction
  function automatic logic [15:0] pk(logic [3:0] a0, logic [3:0] a1, logic [3:0] a2, logic [3:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic vec(input bit rst, input logic [15:0] c, input logic [3:0] m, input exp_t e);
    @(negedge clock);
    reset              = rst;
    cache2mem_msg      = c;
    mem2controller_msg = m;
    q.push_back(e);
    tq.push_back(vid);
    vid++;
  endtask

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      int   t;
      bit   bad;
      e = q.pop_front();
      t = tq.pop_front();
      checks++;
      bad = 1'b0;
      if (bus_control !== e.bc) bad = 1'b1;
      if (bus_en !== e.en)      bad = 1'b1;
      if (curr_master !== e.cm) bad = 1'b1;
      if (req_ready !== e.rr)   bad = 1'b1;
      if (timeout !== e.to)     bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL vec%0d: got bc=%0d en=%0b cm=%b rr=%0b to=%0b, expected bc=%0d en=%0b cm=%b rr=%0b to=%0b",
                 t, bus_control, bus_en, curr_master, req_ready, timeout, e.bc, e.en, e.cm, e.rr, e.to);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vec(1, '0, '0, e_idle());
    vec(1, '0, '0, e_idle());
    vec(0, pk(R_REQ, 0, R_REQ, 0), '0, e_g(0));
    vec(0, pk(R_REQ, 0, R_REQ, 0), '0, e_g(0));
    vec(0, pk(R_REQ, 0, R_REQ, 0), MEM_RESP, e_rsp(0));
    vec(0, pk(NO_REQ, 0, R_REQ, 0), '0, e_idle());
    vec(0, pk(0, 0, R_REQ, 0), '0, e_g(2));
    vec(0, pk(0, 0, NO_REQ, 0), '0, e_idle());
    vec(0, pk(0, 0, 0, R_REQ), '0, e_g(3));
    vec(0, pk(0, 0, 0, NO_REQ), '0, e_idle());
    vec(0, pk(WB_REQ, 0, 0, RFO_BCAST), '0, e_g(0));
    vec(0, pk(NO_REQ, 0, 0, RFO_BCAST), '0, e_idle());
    vec(0, pk(FLUSH, 0, 0, WS_BCAST), '0, e_g(3));
    vec(0, '0, '0, e_idle());
    vec(0, pk(0, R_REQ, 0, 0), '0, e_g(1));
    vec(0, pk(0, R_REQ, C_WB, 0), '0, e_iv(2, 1));
    vec(0, pk(0, R_REQ, C_WB, 0), '0, e_iv(2, 1));
    vec(0, pk(0, R_REQ, NO_REQ, 0), '0, e_g(1));
    vec(0, pk(C_WB, R_REQ, 0, C_FLUSH), MEM_RESP, e_iv(0, 1));
    vec(0, pk(NO_REQ, R_REQ, 0, C_FLUSH), '0, e_g(1));
    vec(0, pk(0, R_REQ, 0, NO_REQ), MEM_RESP_S, e_rsp(1));
    vec(0, pk(0, HOLD_BUS, 0, 0), '0, e_g(1));
    vec(0, pk(R_REQ, R_REQ, 0, 0), MEM_C_RESP, e_rsp(1));
    vec(0, pk(R_REQ, NO_REQ, 0, 0), '0, e_idle());
    vec(0, pk(FLUSH_S, 0, 0, 0), '0, e_g(0));
    vec(0, '0, '0, e_idle());
    vec(0, '0, MEM_RESP, e_idle());
    vec(0, pk(0, R_REQ, 0, 0), '0, e_g(1));
    vec(0, pk(0, R_REQ, 0, 0), MEM_RESP, e_rsp(1));
    vec(1, pk(0, R_REQ, 0, 0), '0, e_idle());
    vec(0, pk(R_REQ, R_REQ, 0, 0), '0, e_g(0));
    vec(0, pk(NO_REQ, R_REQ, 0, 0), '0, e_idle());
    for (int i = 1; i <= 10; i++) begin
`ifdef BUS_WATCHDOG_EN
      if (i == 8)      vec(0, pk(0, 0, R_REQ, 0), '0, mk(2, 1, 4, 0, 1));
      else if (i == 9) vec(0, pk(0, 0, R_REQ, 0), '0, e_idle());
      else             vec(0, pk(0, 0, R_REQ, 0), '0, e_g(2));
`else
      vec(0, pk(0, 0, R_REQ, 0), '0, e_g(2));
`endif
    end
    vec(0, '0, '0, e_idle());
    vec(0, '0, '0, e_idle());
    @(negedge clock);
    @(negedge clock);
    if (checks != vid) begin
      errors++;
      $display("FAIL check_count: got %0d checks, expected %0d", checks, vid);
    end
    if (errors != 0) $display("FAIL summary: got %0d errors, expected 0", errors);
    else             $display("PASS summary: %0d checks", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
